// File: rtl/password_pkg.sv
// Shared types and helpers for the keypad password lock (writer and checker).
package password_pkg;

    localparam int DIGIT_W = 4;
    localparam int BTN_W   = 10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ENTER1   = 3'd1,
        ST_ENTER2   = 3'd2,
        ST_COMMIT   = 3'd3,
        ST_DONE_OK  = 3'd4,
        ST_DONE_ERR = 3'd5
    } state_t;

    localparam logic [1:0] LED_IDLE = 2'b00;
    localparam logic [1:0] LED_OK   = 2'b01;
    localparam logic [1:0] LED_ERR  = 2'b10;

    function automatic logic is_onehot(input logic [BTN_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Meaningful only when the input is one-hot; otherwise returns the highest set index.
    function automatic logic [DIGIT_W-1:0] onehot_to_idx(input logic [BTN_W-1:0] v);
        logic [DIGIT_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < BTN_W; k++) begin
            if (v[k]) idx = DIGIT_W'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_press_det.sv
// Keypad press detector: a press is a one-hot button word following an all-zero word.
module key_press_det
    import password_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [BTN_W-1:0]   button,
    output logic               press,
    output logic [DIGIT_W-1:0] digit
);

    logic [BTN_W-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (rst) r_prev <= '0;
        else     r_prev <= button;
    end

    assign press = is_onehot(button) && (r_prev == '0);
    assign digit = onehot_to_idx(button);

endmodule

// File: rtl/password_writer.sv
// Enrollment front end: capture a code twice, commit it only when both entries agree.
// Optional idle timeout in ENTER1/ENTER2 is built when PASSWORD_WRITER_TIMEOUT_EN is defined.
module password_writer
    import password_pkg::*;
#(
    parameter int                         DIGITS       = 4,
    parameter logic [4*DIGITS-1:0]        DEFAULT_CODE = {DIGITS{4'h0}},
    parameter int                         TIMEOUT_CYC  = 1000
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BTN_W-1:0]      button,
    input  logic                  rmx,
    output logic [4*DIGITS-1:0]   code_out,
    output logic                  code_valid,
    output logic                  busy,
    output logic [1:0]            LED_out,
    output state_t                state_dbg
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                    w_press;
    logic [DIGIT_W-1:0]      w_digit;
    logic                    w_match;
    logic                    w_last;
    logic                    w_timeout;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_mis;
    logic [4*DIGITS-1:0]     r_shadow;
    logic [4*DIGITS-1:0]     r_code;
    logic                    r_valid;
    logic                    r_busy;
    logic [1:0]              r_led;

    key_press_det u_det (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .press  (w_press),
        .digit  (w_digit)
    );

    assign w_match = (r_shadow[r_cnt*DIGIT_W +: DIGIT_W] == w_digit);
    assign w_last  = (r_cnt == CNT_W'(DIGITS - 1));

`ifdef PASSWORD_WRITER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_to_cnt;

    // Held at zero outside the entry states, so entering either state starts from zero.
    always_ff @(posedge clk) begin
        if (rst || w_press || !(r_state == ST_ENTER1 || r_state == ST_ENTER2))
            r_to_cnt <= '0;
        else
            r_to_cnt <= r_to_cnt + 1'b1;
    end

    assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) && !w_press;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_mis    <= 1'b0;
            r_shadow <= '0;
            r_code   <= DEFAULT_CODE;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_led    <= LED_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_ENTER1;
                        r_cnt   <= '0;
                        r_mis   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ENTER1: begin
                    if (w_press) begin
                        r_shadow[r_cnt*DIGIT_W +: DIGIT_W] <= w_digit;
                        if (w_last) begin
                            r_state <= ST_ENTER2;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_DONE_ERR;
                        r_led   <= LED_ERR;
                    end
                end
                ST_ENTER2: begin
                    if (w_press) begin
                        if (!w_match) r_mis <= 1'b1;
                        if (w_last) begin
                            r_cnt <= '0;
                            if (!r_mis && w_match) begin
                                r_state <= ST_COMMIT;
                            end else begin
                                r_state <= ST_DONE_ERR;
                                r_led   <= LED_ERR;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_DONE_ERR;
                        r_led   <= LED_ERR;
                    end
                end
                ST_COMMIT: begin
                    r_code  <= r_shadow;
                    r_valid <= 1'b1;
                    r_state <= ST_DONE_OK;
                    r_led   <= LED_OK;
                end
                ST_DONE_OK, ST_DONE_ERR: begin
                    if (rmx) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_led   <= LED_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_led   <= LED_IDLE;
                end
            endcase
        end
    end

    assign code_out   = r_code;
    assign code_valid = r_valid;
    assign busy       = r_busy;
    assign LED_out    = r_led;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_password_writer.sv
// Directed self-checking bench for password_writer (DIGITS=4, TIMEOUT_CYC=20).
module tb_password_writer;
  import password_pkg::*;

  localparam int DIGITS = 4;
  localparam int TO_CYC = 20;

  logic                clk;
  logic                rst;
  logic                start;
  logic [BTN_W-1:0]    button;
  logic                rmx;
  logic [4*DIGITS-1:0] code_out;
  logic                code_valid;
  logic                busy;
  logic [1:0]          led_out;
  state_t              state_dbg;

  int n_tests;
  int n_fail;

  password_writer #(
    .DIGITS       (DIGITS),
    .DEFAULT_CODE (16'h0000),
    .TIMEOUT_CYC  (TO_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .button     (button),
    .rmx        (rmx),
    .code_out   (code_out),
    .code_valid (code_valid),
    .busy       (busy),
    .LED_out    (led_out),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one cycle: return 1ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_rmx();
    rmx = 1'b1;
    step();
    rmx = 1'b0;
  endtask

  task automatic press(input int d);
    button = 10'(1 << d);
    step();
    button = '0;
    step();
  endtask

  task automatic press_seq(input logic [15:0] digs, input int n);
    for (int i = 0; i < n; i++) press(int'(digs[i*4 +: 4]));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    start   = 1'b0;
    button  = '0;
    rmx     = 1'b0;

    // reset state
    do_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_led", 32'(led_out), 32'(LED_IDLE));
    check("rst_valid", 32'(code_valid), 32'd0);
    check("rst_code", 32'(code_out), 32'h0000);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));

    // matching enrollment 1,2,3,4 / 1,2,3,4
    pulse_start();
    check("t1_enter1", 32'(state_dbg), 32'(ST_ENTER1));
    check("t1_busy", 32'(busy), 32'd1);
    press_seq(16'h4321, 4);
    check("t1_enter2", 32'(state_dbg), 32'(ST_ENTER2));
    press_seq(16'h0321, 3);
    button = 10'(1 << 4);
    step();
    check("t1_commit_state", 32'(state_dbg), 32'(ST_COMMIT));
    check("t1_commit_led", 32'(led_out), 32'(LED_IDLE));
    check("t1_commit_valid", 32'(code_valid), 32'd0);
    button = '0;
    step();
    check("t1_ok_led", 32'(led_out), 32'(LED_OK));
    check("t1_ok_code", 32'(code_out), 32'h4321);
    check("t1_ok_valid", 32'(code_valid), 32'd1);
    pulse_rmx();
    check("t1_rmx_led", 32'(led_out), 32'(LED_IDLE));
    check("t1_rmx_busy", 32'(busy), 32'd0);
    check("t1_rmx_state", 32'(state_dbg), 32'(ST_IDLE));

    // mismatched confirmation 5,6,7,8 / 5,6,9,8
    pulse_start();
    press_seq(16'h8765, 4);
    press_seq(16'h0965, 3);
    button = 10'(1 << 8);
    step();
    check("t2_err_state", 32'(state_dbg), 32'(ST_DONE_ERR));
    check("t2_err_led", 32'(led_out), 32'(LED_ERR));
    button = '0;
    step();
    check("t2_code_kept", 32'(code_out), 32'h4321);
    check("t2_valid_kept", 32'(code_valid), 32'd1);
    pulse_rmx();
    check("t2_rmx_state", 32'(state_dbg), 32'(ST_IDLE));

    // multi-hot ignored, held key counted once, stray rmx/start ignored
    pulse_start();
    pulse_rmx();
    check("t3_rmx_ignored", 32'(state_dbg), 32'(ST_ENTER1));
    button = 10'b0000000011;
    step();
    button = '0;
    step();
    button = 10'(1 << 3);
    repeat (5) step();
    button = '0;
    step();
    press_seq(16'h0421, 3);
    check("t3_enter2", 32'(state_dbg), 32'(ST_ENTER2));
    press_seq(16'h4213, 4);
    check("t3_ok_led", 32'(led_out), 32'(LED_OK));
    check("t3_code", 32'(code_out), 32'h4213);
    pulse_start();
    check("t3_start_ignored", 32'(state_dbg), 32'(ST_DONE_OK));
    check("t3_start_led", 32'(led_out), 32'(LED_OK));
    pulse_rmx();

    // reset in the middle of ENTER2
    pulse_start();
    press_seq(16'h2222, 4);
    press(2);
    check("t4_pre_enter2", 32'(state_dbg), 32'(ST_ENTER2));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_code", 32'(code_out), 32'h0000);
    check("t4_valid", 32'(code_valid), 32'd0);
    check("t4_state", 32'(state_dbg), 32'(ST_IDLE));

`ifdef PASSWORD_WRITER_TIMEOUT_EN
    // two digits then TO_CYC idle cycles -> rejection
    pulse_start();
    press(1);
    press(2);
    repeat (TO_CYC - 2) step();
    check("t5_before_to", 32'(state_dbg), 32'(ST_ENTER1));
    step();
    check("t5_to_state", 32'(state_dbg), 32'(ST_DONE_ERR));
    check("t5_to_led", 32'(led_out), 32'(LED_ERR));
    pulse_rmx();

    // press landing on the timeout cycle is accepted
    pulse_start();
    press(1);
    press(2);
    repeat (TO_CYC - 2) step();
    button = 10'(1 << 3);
    step();
    button = '0;
    check("t6_press_wins", 32'(state_dbg), 32'(ST_ENTER1));
    repeat (5) step();
    check("t6_still_enter1", 32'(state_dbg), 32'(ST_ENTER1));
    press(4);
    check("t6_fourth_digit", 32'(state_dbg), 32'(ST_ENTER2));
    do_reset();
`else
    // without the timeout, entry waits indefinitely
    pulse_start();
    press(1);
    repeat (3 * TO_CYC) step();
    check("t5_no_timeout", 32'(state_dbg), 32'(ST_ENTER1));
    check("t5_no_timeout_led", 32'(led_out), 32'(LED_IDLE));
    do_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
